regwr_arbiter: RTL and testbench
================================

REGWR_ARBITER -- requirements
Module: regwr_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3 (legal 1..7), consecutive lost-arbitration cycles before the buffered MDU result forces priority.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 wb_wr  in  1  primary writeback request from pipeline WB stage.
REQ-005 wb_rw  in  5  WB destination register.
REQ-006 wb_data  in  32  WB write data.
REQ-007 mdu_valid  in  1  multi-cycle unit result valid.
REQ-008 mdu_rw  in  5  MDU destination register.
REQ-009 mdu_data  in  32  MDU result data.
REQ-010 mdu_ready  out  1  buffer can accept an MDU result this cycle.
REQ-011 ra, rb  in  5 each  decode-stage source register numbers for hazard lookup.
REQ-012 hazard_a, hazard_b  out  1 each  source register has a pending buffered write.
REQ-013 RegWr  out  1  register-file write enable.
REQ-014 Rw  out  5  register-file write address.
REQ-015 busW  out  32  register-file write data.
REQ-016 stall  out  1  pipeline hold request; upstream must keep wb_wr=0 while stall=1.
REQ-017 err  out  1  sticky protocol-violation flag.

Function
REQ-018 Block SHALL hold a 2-entry FIFO (rw, data) for MDU results; count range 0..2.
REQ-019 mdu_ready SHALL equal (count != 2), combinational from registered count.
REQ-020 Push SHALL occur when mdu_valid && mdu_ready; if mdu_rw==0 the result is accepted and discarded (no entry).
REQ-021 MDU results SHALL always pass through the FIFO; minimum latency accept-to-RegWr is 1 cycle.
REQ-022 Arbitration per cycle (combinational outputs): if wb_wr && !stall -> grant WB; else if count>0 -> grant FIFO head and pop; else idle.
REQ-023 WB grant: RegWr = (wb_rw != 0), Rw = wb_rw, busW = wb_data; WB writes to register 0 SHALL be suppressed.
REQ-024 FIFO grant: RegWr=1, Rw/busW = head entry.
REQ-025 When RegWr=0, Rw and busW SHALL be 0.
REQ-026 Push and pop in same cycle SHALL leave count unchanged and preserve order; push at count 0 is not popped until the following cycle.
REQ-027 starve_cnt (3 bits): increments when count>0 and WB wins; clears on any pop or when count==0; saturates at STARVE_LIMIT.
REQ-028 stall SHALL equal (starve_cnt == STARVE_LIMIT), taken from registered state.
REQ-029 While stall=1, wb_wr SHALL be ignored (no WB write); FIFO head is granted, pop clears starve_cnt, stall drops the next cycle.
REQ-030 wb_wr=1 while stall=1 SHALL set err on the next edge; err remains 1 until rst.
REQ-031 hazard_a SHALL be 1 iff ra!=0 and any valid FIFO entry (including one popping this cycle) has rw==ra; hazard_b identically for rb.
REQ-032 FIFO pointers SHALL wrap modulo 2; no overflow possible since push requires mdu_ready.

Reset
REQ-033 On rst=1 at a rising edge: count=0, pointers=0, starve_cnt=0, err=0; FIFO contents discarded including entries mid-wait.
REQ-034 During and after reset, until the next push or wb_wr: RegWr=0, Rw=0, busW=0, stall=0, mdu_ready=1, hazard_a=hazard_b=0.
REQ-035 rst SHALL dominate simultaneous push/pop in the same cycle.

Verification
REQ-036 wb_wr=1, wb_rw=5, wb_data=0xDEADBEEF, FIFO empty -> same cycle RegWr=1, Rw=5, busW=0xDEADBEEF; wb_rw=0 -> RegWr=0.
REQ-037 Push mdu_rw=7/0x11, then mdu_rw=8/0x22 while wb_wr=1 -> count=2, mdu_ready=0, hazard_a=1 for ra=7; on wb_wr=0 writes 7/0x11 then 8/0x22 in consecutive cycles.
REQ-038 STARVE_LIMIT=3, one FIFO entry, wb_wr=1 continuously -> stall=1 after 3 lost cycles; upstream drops wb_wr; head written in stall cycle; stall=0 next cycle.
REQ-039 Keep wb_wr=1 during stall -> no WB write that cycle, err=1 next edge and stays 1 until rst.
REQ-040 Fill FIFO to 2, assert rst for one cycle -> count=0, mdu_ready=1, no further RegWr from discarded entries, err=0, stall=0.
REQ-041 mdu_valid with mdu_rw=0 -> accepted (mdu_ready=1), no entry, no RegWr ever issued for it.

Source files
------------

// File: rtl/regwr_arbiter_if.sv
// Register-file write port bundle: pipeline writeback, multi-cycle unit results,
// decode-stage hazard lookup and the arbitrated register-file write.
interface regwr_arbiter_if;
    logic        wb_wr;
    logic [4:0]  wb_rw;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rw;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        hazard_a;
    logic        hazard_b;
    logic        RegWr;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic        stall;
    logic        err;
    logic [1:0]  dbg_count;
    logic [2:0]  dbg_starve;

    // MDU handshake: a result transfers on a cycle where mdu_valid && mdu_ready.
    // WB has no handshake; the upstream stage must hold wb_wr=0 while stall=1.
    modport master (
        output wb_wr, wb_rw, wb_data, mdu_valid, mdu_rw, mdu_data, ra, rb,
        input  mdu_ready, hazard_a, hazard_b, RegWr, Rw, busW, stall, err,
        input  dbg_count, dbg_starve
    );

    modport slave (
        input  wb_wr, wb_rw, wb_data, mdu_valid, mdu_rw, mdu_data, ra, rb,
        output mdu_ready, hazard_a, hazard_b, RegWr, Rw, busW, stall, err,
        output dbg_count, dbg_starve
    );
endinterface

// File: rtl/regwr_arbiter.sv
// Shares one register-file write port between the WB stage and a 2-entry MDU
// result buffer; WB wins unless the buffered result has starved STARVE_LIMIT cycles.
module regwr_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic           clk,
    input  logic           rst,
    regwr_arbiter_if.slave bus
);
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [1:0]  count;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [4:0]  fifo_rw   [2];
    logic [31:0] fifo_data [2];
    logic [2:0]  starve_cnt;
    logic        err_q;

    logic        stall_int;
    logic        grant_wb;
    logic        push;
    logic        pop;
    logic [1:0]  entry_valid;

    // Reset masks all grants so nothing buffered before reset can reach the register file.
    always_comb begin
        stall_int      = !rst && (starve_cnt == LIMIT);
        grant_wb       = !rst && bus.wb_wr && !stall_int;
        pop            = !rst && !grant_wb && (count != 2'd0);
        push           = !rst && bus.mdu_valid && (count != 2'd2) && (bus.mdu_rw != 5'd0);
        entry_valid[0] = !rst && ((count == 2'd2) || ((count == 2'd1) && !rd_ptr));
        entry_valid[1] = !rst && ((count == 2'd2) || ((count == 2'd1) && rd_ptr));
    end

    always_comb begin
        bus.RegWr      = 1'b0;
        bus.Rw         = 5'd0;
        bus.busW       = 32'd0;
        bus.stall      = stall_int;
        bus.err        = err_q;
        bus.mdu_ready  = rst || (count != 2'd2);
        bus.dbg_count  = count;
        bus.dbg_starve = starve_cnt;
        bus.hazard_a   = (bus.ra != 5'd0) &&
                         ((entry_valid[0] && (fifo_rw[0] == bus.ra)) ||
                          (entry_valid[1] && (fifo_rw[1] == bus.ra)));
        bus.hazard_b   = (bus.rb != 5'd0) &&
                         ((entry_valid[0] && (fifo_rw[0] == bus.rb)) ||
                          (entry_valid[1] && (fifo_rw[1] == bus.rb)));
        if (grant_wb) begin
            if (bus.wb_rw != 5'd0) begin
                bus.RegWr = 1'b1;
                bus.Rw    = bus.wb_rw;
                bus.busW  = bus.wb_data;
            end
        end else if (pop) begin
            bus.RegWr = 1'b1;
            bus.Rw    = fifo_rw[rd_ptr];
            bus.busW  = fifo_data[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            starve_cnt <= 3'd0;
            err_q      <= 1'b0;
        end else begin
            if (push) begin
                fifo_rw[wr_ptr]   <= bus.mdu_rw;
                fifo_data[wr_ptr] <= bus.mdu_data;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            // Starvation only accrues while something is buffered and WB took the port.
            if (pop || (count == 2'd0)) begin
                starve_cnt <= 3'd0;
            end else if (grant_wb && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
            if (stall_int && bus.wb_wr) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regwr_arbiter.sv
// Self-checking bench for regwr_arbiter: per-cycle vector table with a write
// scoreboard, followed by a hand-built starvation sequence.
module tb_regwr_arbiter;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [36:0] exp_q[$];

    regwr_arbiter_if bus ();

    regwr_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        w;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        m;
        logic [4:0]  mr;
        logic [31:0] md;
        logic [4:0]  a;
        logic [4:0]  b;
        logic        e_wr;
        logic [4:0]  e_rw;
        logic [31:0] e_bw;
        logic        e_st;
        logic        e_rdy;
        logic        e_ha;
        logic        e_hb;
        logic        e_err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic w, logic [4:0] wr, logic [31:0] wd,
                                logic m, logic [4:0] mr, logic [31:0] md,
                                logic [4:0] a, logic [4:0] b,
                                logic e_wr, logic [4:0] e_rw, logic [31:0] e_bw,
                                logic e_st, logic e_rdy, logic e_ha, logic e_hb, logic e_err);
        vec_t v;
        v.r = r; v.w = w; v.wr = wr; v.wd = wd; v.m = m; v.mr = mr; v.md = md;
        v.a = a; v.b = b; v.e_wr = e_wr; v.e_rw = e_rw; v.e_bw = e_bw;
        v.e_st = e_st; v.e_rdy = e_rdy; v.e_ha = e_ha; v.e_hb = e_hb; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [36:0] act, input logic [36:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst           = v.r;
        bus.wb_wr     = v.w;
        bus.wb_rw     = v.wr;
        bus.wb_data   = v.wd;
        bus.mdu_valid = v.m;
        bus.mdu_rw    = v.mr;
        bus.mdu_data  = v.md;
        bus.ra        = v.a;
        bus.rb        = v.b;
    endtask

    task automatic check_write(input int idx);
        logic [36:0] e;
        if (bus.RegWr === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write vec=%0d actual=%0d/%h required=none", idx, bus.Rw, bus.busW);
            end else begin
                n_vec--;
                e = exp_q.pop_front();
                chk("write_data", idx, {bus.Rw, bus.busW}, e);
            end
        end else begin
            chk("idle_bus", idx, {bus.Rw, bus.busW}, 37'd0);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    endtask

    initial begin
        int lost;
        logic seen;
        n_vec = 0;
        n_err = 0;

        //        r  w  wr  wd            m  mr  md        a   b   ewr erw ebw           st rdy ha hb er
        vt.push_back(mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    0,  0,  0, 0,  32'h0,        0, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 5,  32'hDEADBEEF, 0, 0,  32'h0,    0,  0,  1, 5,  32'hDEADBEEF, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 0,  32'h12345678, 0, 0,  32'h0,    0,  0,  0, 0,  32'h0,        0, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 3,  32'hA3,       1, 7,  32'h11,   7,  0,  1, 3,  32'hA3,       0, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 4,  32'hA4,       1, 8,  32'h22,   7,  8,  1, 4,  32'hA4,       0, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0,  32'h0,        1, 9,  32'h33,   7,  8,  1, 7,  32'h11,       0, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0,  32'h0,        0, 0,  32'h0,    7,  8,  1, 8,  32'h22,       0, 1, 0, 1, 0));
        vt.push_back(mk(0, 0, 0,  32'h0,        0, 0,  32'h0,    8,  9,  0, 0,  32'h0,        0, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 1,  32'hB1,       1, 10, 32'h44,   0,  0,  1, 1,  32'hB1,       0, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 2,  32'hB2,       0, 0,  32'h0,    10, 0,  1, 2,  32'hB2,       0, 1, 1, 0, 0));
        vt.push_back(mk(0, 1, 3,  32'hB3,       0, 0,  32'h0,    0,  0,  1, 3,  32'hB3,       0, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 4,  32'hB4,       0, 0,  32'h0,    0,  0,  1, 4,  32'hB4,       0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0,  32'h0,        0, 0,  32'h0,    10, 0,  1, 10, 32'h44,       1, 1, 1, 0, 0));
        vt.push_back(mk(0, 1, 5,  32'hB5,       0, 0,  32'h0,    10, 0,  1, 5,  32'hB5,       0, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 6,  32'hC6,       1, 11, 32'h55,   0,  0,  1, 6,  32'hC6,       0, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 6,  32'hC7,       0, 0,  32'h0,    0,  11, 1, 6,  32'hC7,       0, 1, 0, 1, 0));
        vt.push_back(mk(0, 1, 6,  32'hC8,       0, 0,  32'h0,    0,  0,  1, 6,  32'hC8,       0, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 6,  32'hC9,       0, 0,  32'h0,    0,  0,  1, 6,  32'hC9,       0, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 12, 32'hCA,       0, 0,  32'h0,    0,  0,  1, 11, 32'h55,       1, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0,  32'h0,        0, 0,  32'h0,    0,  0,  0, 0,  32'h0,        0, 1, 0, 0, 1));
        vt.push_back(mk(0, 1, 13, 32'hCB,       0, 0,  32'h0,    0,  0,  1, 13, 32'hCB,       0, 1, 0, 0, 1));
        vt.push_back(mk(0, 1, 15, 32'hCC,       1, 14, 32'h66,   0,  0,  1, 15, 32'hCC,       0, 1, 0, 0, 1));
        vt.push_back(mk(0, 1, 15, 32'hCD,       1, 16, 32'h77,   14, 0,  1, 15, 32'hCD,       0, 1, 1, 0, 1));
        vt.push_back(mk(1, 0, 0,  32'h0,        1, 18, 32'h88,   14, 16, 0, 0,  32'h0,        0, 1, 0, 0, 1));
        vt.push_back(mk(0, 0, 0,  32'h0,        0, 0,  32'h0,    14, 16, 0, 0,  32'h0,        0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0,  32'h0,        0, 0,  32'h0,    18, 0,  0, 0,  32'h0,        0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0,  32'h0,        1, 0,  32'h99,   0,  0,  0, 0,  32'h0,        0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0,  32'h0,        0, 0,  32'h0,    0,  0,  0, 0,  32'h0,        0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0,  32'h0,        1, 20, 32'hD0,   20, 0,  0, 0,  32'h0,        0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0,  32'h0,        1, 21, 32'hD1,   20, 21, 1, 20, 32'hD0,       0, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0,  32'h0,        0, 0,  32'h0,    20, 21, 1, 21, 32'hD1,       0, 1, 0, 1, 0));
        vt.push_back(mk(0, 0, 0,  32'h0,        0, 0,  32'h0,    20, 21, 0, 0,  32'h0,        0, 1, 0, 0, 0));

        // Bring registered state out of X before the table starts.
        drive(vt[0]);
        @(posedge clk);

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vt[i]);
            if (vt[i].e_wr) exp_q.push_back({vt[i].e_rw, vt[i].e_bw});
            #4;
            chk("RegWr", i, 37'(bus.RegWr), 37'(vt[i].e_wr));
            chk("stall", i, 37'(bus.stall), 37'(vt[i].e_st));
            chk("mdu_ready", i, 37'(bus.mdu_ready), 37'(vt[i].e_rdy));
            chk("hazard_a", i, 37'(bus.hazard_a), 37'(vt[i].e_ha));
            chk("hazard_b", i, 37'(bus.hazard_b), 37'(vt[i].e_hb));
            chk("err", i, 37'(bus.err), 37'(vt[i].e_err));
            check_write(i);
        end
        chk("queue_drained", 99, 37'(exp_q.size()), 37'd0);

        // Starvation: one buffered result, WB held busy until stall appears.
        @(posedge clk);
        #1;
        drive(mk(0, 1, 2, 32'hF0, 1, 22, 32'hE0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #4;
        chk("starve_wb_first", 100, {bus.RegWr, bus.Rw, bus.busW[30:0]}, {1'b1, 5'd2, 31'hF0});
        lost = 0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk);
            #1;
            bus.mdu_valid = 1'b0;
            bus.wb_wr     = 1'b1;
            #4;
            if (bus.stall === 1'b1) begin
                seen      = 1'b1;
                bus.wb_wr = 1'b0;
                #1;
                chk("stall_head_write", 101, {bus.RegWr, bus.Rw, bus.busW[30:0]}, {1'b1, 5'd22, 31'hE0});
            end else begin
                lost++;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL stall_timeout actual=no_stall required=stall_within_10");
        end
        chk("lost_cycles", 102, 37'(lost), 37'd3);
        @(posedge clk);
        #1;
        bus.wb_wr = 1'b0;
        #4;
        chk("stall_released", 103, 37'(bus.stall), 37'd0);
        chk("fifo_empty", 104, 37'(bus.dbg_count), 37'd0);
        chk("err_clear", 105, 37'(bus.err), 37'd0);
        chk("no_extra_write", 106, 37'(bus.RegWr), 37'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
